// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with a three-state sequencer.
// Stalls the pipeline while iterating; special cases may short-circuit to DONE.
module div_sequencer #(
  parameter int unsigned FAST_SPECIAL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_func,
  input  logic [31:0] req_opa,
  input  logic [31:0] req_opb,
  input  logic        flush,
  output logic        stall_out,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result
);

  localparam bit FAST = (FAST_SPECIAL != 32'd0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [31:0] special_result(input logic [1:0] func,
                                                 input logic [31:0] opa,
                                                 input logic div0);
    logic [31:0] res;
    if (div0) begin
      res = func[1] ? opa : 32'hFFFF_FFFF;
    end else begin
      res = func[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
    return res;
  endfunction

  // Sign flags are only ever set for signed ops, so no func check is needed here.
  function automatic logic [31:0] fixup(input logic [1:0] func,
                                        input logic [31:0] quo,
                                        input logic [31:0] rem,
                                        input logic neg_a,
                                        input logic neg_b,
                                        input logic div0);
    logic [31:0] q;
    logic [31:0] r;
    q = (neg_a ^ neg_b) ? (32'd0 - quo) : quo;
    if (div0) begin
      q = 32'hFFFF_FFFF;
    end else begin
      q = q;
    end
    r = neg_a ? (32'd0 - rem) : rem;
    return func[1] ? r : q;
  endfunction

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [1:0]  func_q, func_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic        div0_q, div0_d;
  logic [31:0] stage_q, stage_d;
  logic [31:0] result_q, result_d;

  logic        req_signed, req_neg_a, req_neg_b, req_div0, req_ovf;
  logic [31:0] abs_a, abs_b;
  logic [33:0] shifted, diff;
  logic [32:0] step_rem;
  logic [31:0] step_quo;

  // One restoring step on the current partial remainder/quotient.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {2'b00, dvsr_q};
    if (diff[33]) begin
      step_rem = shifted[32:0];
      step_quo = {quo_q[30:0], 1'b0};
    end else begin
      step_rem = diff[32:0];
      step_quo = {quo_q[30:0], 1'b1};
    end
  end

  // Request decode: signedness, magnitudes and special-case detection.
  always_comb begin
    req_signed = ~req_func[0];
    req_neg_a  = req_signed & req_opa[31];
    req_neg_b  = req_signed & req_opb[31];
    abs_a      = req_neg_a ? (32'd0 - req_opa) : req_opa;
    abs_b      = req_neg_b ? (32'd0 - req_opb) : req_opb;
    req_div0   = (req_opb == 32'd0);
    req_ovf    = req_signed && (req_opa == 32'h8000_0000) && (req_opb == 32'hFFFF_FFFF);
  end

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    func_d   = func_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    div0_d   = div0_q;
    stage_d  = stage_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          func_d  = req_func;
          neg_a_d = req_neg_a;
          neg_b_d = req_neg_b;
          div0_d  = req_div0;
          quo_d   = abs_a;
          dvsr_d  = abs_b;
          rem_d   = 33'd0;
          cnt_d   = 5'd0;
          if (FAST && (req_div0 || req_ovf)) begin
            stage_d = special_result(req_func, req_opa, req_div0);
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            stage_d = fixup(func_q, step_quo, step_rem[31:0], neg_a_q, neg_b_q, div0_q);
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!flush) begin
          result_d = stage_q;
        end else begin
          result_d = result_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      rem_q    <= 33'd0;
      quo_q    <= 32'd0;
      dvsr_q   <= 32'd0;
      func_q   <= 2'd0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      stage_q  <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      func_q   <= func_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      div0_q   <= div0_d;
      stage_q  <= stage_d;
      result_q <= result_d;
    end
  end

  // Handshake outputs; a flush in DONE suppresses the pulse and keeps the old result.
  always_comb begin
    stall_out    = ((state_q == IDLE) && req_valid && !flush) || (state_q == CALC);
    busy         = (state_q != IDLE);
    result_valid = (state_q == DONE) && !flush;
    if (result_valid) begin
      result = stage_q;
    end else begin
      result = result_q;
    end
  end

endmodule
